j11_bus_arb: RTL and testbench

J11_BUS_ARB -- requirements
Module: j11_bus_arb

---
 rtl/j11_pkg.sv | 38 +++
 rtl/j11_bus_slot.sv | 34 +++
 rtl/j11_bus_arb.sv | 203 ++++++++++++++++++++
 tb/tb_j11_bus_arb.sv | 505 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/j11_pkg.sv
// Shared types and constants for the J11 bus arbiter.
package j11_pkg;

  localparam int ADDR_W = 22;
  localparam int DATA_W = 16;

  // Requester identities, used for owner and the last-winner register
  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

  // Read data returned to a requester whose transfer timed out
  localparam logic [DATA_W-1:0] TIMEOUT_RDATA = 16'hFFFF;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_t;

  // Contents of one pending request
  typedef struct packed {
    logic              wr;
    logic              gp;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } slot_t;

  // Pick a winner from the pending mask {dma, cpu}. On a tie the requester
  // that did not win the previous tie goes first.
  function automatic logic pick_winner(input logic [1:0] pend, input logic last);
    if (pend == 2'b11) begin
      return ~last;
    end
    return pend[1];
  endfunction

endpackage

// File: rtl/j11_bus_slot.sv
// One requester's pending slot: latches a request pulse and holds it until
// the arbiter clears it at the end of the transfer.
module j11_bus_slot
  import j11_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  req,
  input  slot_t req_data,
  input  logic  clr,
  output logic  pending,
  output slot_t data
);

  logic  pending_reg;
  slot_t data_reg;

  // Capture a request only when the slot is free; repeats while busy are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_reg <= 1'b0;
      data_reg    <= '0;
    end else if (clr) begin
      pending_reg <= 1'b0;
    end else if (req && !pending_reg) begin
      pending_reg <= 1'b1;
      data_reg    <= req_data;
    end
  end

  assign pending = pending_reg;
  assign data    = data_reg;

endmodule

// File: rtl/j11_bus_arb.sv
// J11 bus arbiter: two requesters (CPU, DMA) share a memory target and an
// I/O-page target. One transfer is in flight at a time; a stuck target is
// released by a timeout that returns all-ones data and pulses buserr.
module j11_bus_arb
  import j11_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  // CPU requester
  input  logic        c_req,
  input  logic        c_wr,
  input  logic        c_gp,
  input  logic [21:0] c_addr,
  input  logic [15:0] c_wdata,
  output logic        c_ack,
  output logic [15:0] c_rdata,
  // DMA requester
  input  logic        d_req,
  input  logic        d_wr,
  input  logic        d_gp,
  input  logic [21:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ack,
  output logic [15:0] d_rdata,
  // memory target
  output logic        m_req,
  output logic        m_wr,
  output logic [21:0] m_addr,
  output logic [15:0] m_wdata,
  input  logic        m_ack,
  input  logic [15:0] m_rdata,
  // I/O-page target
  output logic        io_req,
  output logic        io_wr,
  output logic [21:0] io_addr,
  output logic [15:0] io_wdata,
  input  logic        io_ack,
  input  logic [15:0] io_rdata,
  // status
  output logic        buserr,
  output logic        owner
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  // Per-requester slot wiring, index 0 = CPU, 1 = DMA
  logic [1:0] req_v;
  logic [1:0] pend_v;
  logic [1:0] clr_v;
  slot_t      req_data_v [2];
  slot_t      slot_v     [2];

  arb_state_t       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             last_reg;
  logic             owner_reg;
  logic             sel_io_reg;

  logic        m_req_reg, m_wr_reg;
  logic [21:0] m_addr_reg;
  logic [15:0] m_wdata_reg;
  logic        io_req_reg, io_wr_reg;
  logic [21:0] io_addr_reg;
  logic [15:0] io_wdata_reg;
  logic        c_ack_reg, d_ack_reg, buserr_reg;
  logic [15:0] c_rdata_reg, d_rdata_reg;

  logic        win;
  slot_t       win_slot;
  logic        sel_ack;
  logic [15:0] sel_rdata;
  logic        timeout_hit;
  logic        done;

  assign req_v         = {d_req, c_req};
  assign req_data_v[0] = {c_wr, c_gp, c_addr, c_wdata};
  assign req_data_v[1] = {d_wr, d_gp, d_addr, d_wdata};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      j11_bus_slot u_slot (
        .clk      (clk),
        .rst      (rst),
        .req      (req_v[gi]),
        .req_data (req_data_v[gi]),
        .clr      (clr_v[gi]),
        .pending  (pend_v[gi]),
        .data     (slot_v[gi])
      );
    end
  endgenerate

  assign win      = pick_winner(pend_v, last_reg);
  assign win_slot = slot_v[win];

  // Only the target that was actually issued to can complete the transfer
  assign sel_ack     = sel_io_reg ? io_ack   : m_ack;
  assign sel_rdata   = sel_io_reg ? io_rdata : m_rdata;
  assign timeout_hit = (cnt_reg == CNT_MAX);

  // The slot is freed on the same edge that registers the ack, so the
  // requester may post a fresh request during its ack cycle.
  assign done  = (state_reg == ST_WAIT) && (sel_ack || timeout_hit);
  assign clr_v = done ? ((owner_reg == REQ_DMA) ? 2'b10 : 2'b01) : 2'b00;

  // Sequencer: arbitrate in IDLE, pulse the target in ISSUE, finish in WAIT.
  // last_reg only moves on contested grants, so back-to-back simultaneous
  // pairs alternate who goes first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      last_reg     <= REQ_DMA;
      owner_reg    <= REQ_CPU;
      sel_io_reg   <= 1'b0;
      m_req_reg    <= 1'b0;
      m_wr_reg     <= 1'b0;
      m_addr_reg   <= '0;
      m_wdata_reg  <= '0;
      io_req_reg   <= 1'b0;
      io_wr_reg    <= 1'b0;
      io_addr_reg  <= '0;
      io_wdata_reg <= '0;
      c_ack_reg    <= 1'b0;
      d_ack_reg    <= 1'b0;
      buserr_reg   <= 1'b0;
      c_rdata_reg  <= '0;
      d_rdata_reg  <= '0;
    end else begin
      m_req_reg  <= 1'b0;
      io_req_reg <= 1'b0;
      c_ack_reg  <= 1'b0;
      d_ack_reg  <= 1'b0;
      buserr_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (pend_v != 2'b00) begin
            owner_reg  <= win;
            sel_io_reg <= win_slot.gp;
            if (pend_v == 2'b11) begin
              last_reg <= win;
            end
            if (win_slot.gp) begin
              io_req_reg   <= 1'b1;
              io_wr_reg    <= win_slot.wr;
              io_addr_reg  <= win_slot.addr;
              io_wdata_reg <= win_slot.wdata;
            end else begin
              m_req_reg   <= 1'b1;
              m_wr_reg    <= win_slot.wr;
              m_addr_reg  <= win_slot.addr;
              m_wdata_reg <= win_slot.wdata;
            end
            state_reg <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt_reg   <= '0;
          state_reg <= ST_WAIT;
        end
        ST_WAIT: begin
          if (sel_ack || timeout_hit) begin
            // A real ack wins over a coincident timeout
            if (owner_reg == REQ_DMA) begin
              d_ack_reg   <= 1'b1;
              d_rdata_reg <= sel_ack ? sel_rdata : TIMEOUT_RDATA;
            end else begin
              c_ack_reg   <= 1'b1;
              c_rdata_reg <= sel_ack ? sel_rdata : TIMEOUT_RDATA;
            end
            buserr_reg <= ~sel_ack;
            state_reg  <= ST_IDLE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign m_req    = m_req_reg;
  assign m_wr     = m_wr_reg;
  assign m_addr   = m_addr_reg;
  assign m_wdata  = m_wdata_reg;
  assign io_req   = io_req_reg;
  assign io_wr    = io_wr_reg;
  assign io_addr  = io_addr_reg;
  assign io_wdata = io_wdata_reg;
  assign c_ack    = c_ack_reg;
  assign d_ack    = d_ack_reg;
  assign c_rdata  = c_rdata_reg;
  assign d_rdata  = d_rdata_reg;
  assign buserr   = buserr_reg;
  assign owner    = owner_reg;

endmodule

// File: tb/tb_j11_bus_arb.sv
// Self-checking bench for j11_bus_arb: directed scenarios plus a randomized
// transaction run checked against a request-order / data model.
module tb_j11_bus_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req, c_wr, c_gp;
  logic [21:0] c_addr;
  logic [15:0] c_wdata;
  logic        c_ack;
  logic [15:0] c_rdata;
  logic        d_req, d_wr, d_gp;
  logic [21:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_ack;
  logic [15:0] d_rdata;
  logic        m_req, m_wr;
  logic [21:0] m_addr;
  logic [15:0] m_wdata;
  logic        m_ack;
  logic [15:0] m_rdata;
  logic        io_req, io_wr;
  logic [21:0] io_addr;
  logic [15:0] io_wdata;
  logic        io_ack;
  logic [15:0] io_rdata;
  logic        buserr;
  logic        owner;

  int checks   = 0;
  int failures = 0;

  int m_req_cnt  = 0;
  int io_req_cnt = 0;
  int buserr_cnt = 0;
  int c_ack_cnt  = 0;
  int d_ack_cnt  = 0;

  j11_bus_arb #(.TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_wr(c_wr), .c_gp(c_gp), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_ack(c_ack), .c_rdata(c_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_gp(d_gp), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata),
    .io_req(io_req), .io_wr(io_wr), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_ack(io_ack), .io_rdata(io_rdata),
    .buserr(buserr), .owner(owner)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled mid-cycle
  always @(negedge clk) begin
    if (m_req === 1'b1)  m_req_cnt++;
    if (io_req === 1'b1) io_req_cnt++;
    if (buserr === 1'b1) buserr_cnt++;
    if (c_ack === 1'b1)  c_ack_cnt++;
    if (d_ack === 1'b1)  d_ack_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    c_req = 0; c_wr = 0; c_gp = 0; c_addr = '0; c_wdata = '0;
    d_req = 0; d_wr = 0; d_gp = 0; d_addr = '0; d_wdata = '0;
    m_ack = 0; m_rdata = '0; io_ack = 0; io_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_treq(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (m_req === 1'b1 || io_req === 1'b1) begin
        got = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    int m0;
    rst = 1'b1;
    idle_inputs();
    c_req = 1'b1; d_req = 1'b1;
    tick();
    tick();
    c_req = 1'b0; d_req = 1'b0;
    checks++;
    if ({m_req, io_req, c_ack, d_ack, buserr, owner} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=000000", {m_req, io_req, c_ack, d_ack, buserr, owner});
    end
    checks++;
    if ({c_rdata, d_rdata} !== 32'h0) begin
      failures++;
      $display("FAIL reset_rdata got=%h exp=0", {c_rdata, d_rdata});
    end
    checks++;
    if ({m_wr, m_addr, m_wdata, io_wr, io_addr, io_wdata} !== 78'h0) begin
      failures++;
      $display("FAIL reset_bus got=%h exp=0", {m_wr, m_addr, m_wdata, io_wr, io_addr, io_wdata});
    end
    m0 = m_req_cnt + io_req_cnt;
    rst = 1'b0;
    repeat (5) tick();
    checks++;
    if (m_req_cnt + io_req_cnt - m0 !== 0) begin
      failures++;
      $display("FAIL reset_req_dropped got=%0d exp=0 target requests", m_req_cnt + io_req_cnt - m0);
    end
    $display("test_reset done");
  endtask

  task automatic test_io_read();
    int m0, io0;
    m0 = m_req_cnt; io0 = io_req_cnt;
    c_gp = 1'b1; c_wr = 1'b0; c_addr = 22'o17777776; c_wdata = 16'h0;
    c_req = 1'b1;
    tick();
    c_req = 1'b0;
    checks++;
    if (io_req !== 1'b0) begin
      failures++;
      $display("FAIL io_req_early got=%b exp=0", io_req);
    end
    tick();
    checks++;
    if (io_req !== 1'b1 || m_req !== 1'b0) begin
      failures++;
      $display("FAIL io_req_latency got io_req=%b m_req=%b exp io_req=1 m_req=0", io_req, m_req);
    end
    checks++;
    if (io_addr !== 22'o17777776 || io_wr !== 1'b0 || owner !== 1'b0) begin
      failures++;
      $display("FAIL io_bus got addr=%o wr=%b owner=%b exp addr=17777776 wr=0 owner=0", io_addr, io_wr, owner);
    end
    repeat (3) tick();
    io_ack = 1'b1; io_rdata = 16'o123456;
    tick();
    io_ack = 1'b0; io_rdata = 16'h0;
    checks++;
    if (c_ack !== 1'b1 || c_rdata !== 16'o123456) begin
      failures++;
      $display("FAIL io_c_ack got ack=%b rdata=%o exp ack=1 rdata=123456", c_ack, c_rdata);
    end
    checks++;
    if (owner !== 1'b0 || d_ack !== 1'b0 || buserr !== 1'b0) begin
      failures++;
      $display("FAIL io_side got owner=%b d_ack=%b buserr=%b exp 0 0 0", owner, d_ack, buserr);
    end
    tick();
    checks++;
    if (c_ack !== 1'b0 || c_rdata !== 16'o123456) begin
      failures++;
      $display("FAIL io_hold got ack=%b rdata=%o exp ack=0 rdata=123456", c_ack, c_rdata);
    end
    tick();
    checks++;
    if (io_req_cnt - io0 !== 1 || m_req_cnt - m0 !== 0) begin
      failures++;
      $display("FAIL io_counts got io=%0d m=%0d exp io=1 m=0", io_req_cnt - io0, m_req_cnt - m0);
    end
    $display("test_io_read done");
  endtask

  task automatic test_tie();
    logic [21:0] ca, da;
    logic [15:0] cw, dw, rd;
    logic        first, exp_o;
    bit          got;
    do_reset();
    for (int p = 0; p < 2; p++) begin
      ca = 22'($urandom); da = 22'($urandom);
      cw = 16'($urandom); dw = 16'($urandom);
      c_wr = 1; c_gp = 0; c_addr = ca; c_wdata = cw;
      d_wr = 1; d_gp = 0; d_addr = da; d_wdata = dw;
      c_req = 1; d_req = 1;
      tick();
      c_req = 0; d_req = 0;
      first = (p == 0) ? 1'b0 : 1'b1;
      for (int s = 0; s < 2; s++) begin
        exp_o = (s == 0) ? first : ~first;
        wait_treq(8, got);
        checks++;
        if (!got || m_req !== 1'b1 || io_req !== 1'b0 || owner !== exp_o) begin
          failures++;
          $display("FAIL tie_grant pair=%0d slot=%0d got m_req=%b owner=%b exp m_req=1 owner=%b", p, s, m_req, owner, exp_o);
        end
        checks++;
        if (m_wr !== 1'b1 || m_addr !== (exp_o ? da : ca) || m_wdata !== (exp_o ? dw : cw)) begin
          failures++;
          $display("FAIL tie_bus pair=%0d got addr=%h wdata=%h exp addr=%h wdata=%h", p, m_addr, m_wdata, exp_o ? da : ca, exp_o ? dw : cw);
        end
        repeat ($urandom_range(1, 4)) tick();
        rd = 16'($urandom);
        m_ack = 1; m_rdata = rd;
        tick();
        m_ack = 0;
        checks++;
        if ({d_ack, c_ack} !== (exp_o ? 2'b10 : 2'b01) || (exp_o ? d_rdata : c_rdata) !== rd) begin
          failures++;
          $display("FAIL tie_ack pair=%0d got d_ack=%b c_ack=%b exp owner=%b rdata=%h", p, d_ack, c_ack, exp_o, rd);
        end
      end
    end
    $display("test_tie done");
  endtask

  task automatic test_timeout();
    int  b0, a0;
    bit  early;
    b0 = buserr_cnt; a0 = d_ack_cnt;
    d_gp = 0; d_wr = 0; d_addr = 22'($urandom);
    d_req = 1;
    tick();
    d_req = 0;
    tick();
    checks++;
    if (m_req !== 1'b1 || owner !== 1'b1) begin
      failures++;
      $display("FAIL to_issue got m_req=%b owner=%b exp 1 1", m_req, owner);
    end
    early = 0;
    for (int i = 1; i <= 256; i++) begin
      tick();
      if (d_ack !== 1'b0 || buserr !== 1'b0) early = 1;
    end
    checks++;
    if (early) begin
      failures++;
      $display("FAIL to_early got ack/buserr before 256 wait cycles exp none");
    end
    tick();
    checks++;
    if (d_ack !== 1'b1 || d_rdata !== 16'hFFFF || buserr !== 1'b1) begin
      failures++;
      $display("FAIL to_fire got d_ack=%b d_rdata=%h buserr=%b exp 1 ffff 1", d_ack, d_rdata, buserr);
    end
    tick();
    tick();
    checks++;
    if (buserr_cnt - b0 !== 1 || d_ack_cnt - a0 !== 1) begin
      failures++;
      $display("FAIL to_counts got buserr=%0d d_ack=%0d exp 1 1", buserr_cnt - b0, d_ack_cnt - a0);
    end
    $display("test_timeout done");
  endtask

  task automatic test_ack_at_timeout();
    int          b0;
    bit          early;
    logic [15:0] rd;
    b0 = buserr_cnt;
    c_gp = 0; c_wr = 0; c_addr = 22'($urandom);
    c_req = 1;
    tick();
    c_req = 0;
    tick();
    early = 0;
    for (int i = 1; i <= 256; i++) begin
      tick();
      if (c_ack !== 1'b0) early = 1;
    end
    rd = 16'($urandom);
    m_ack = 1; m_rdata = rd;
    tick();
    m_ack = 0;
    checks++;
    if (early || c_ack !== 1'b1 || c_rdata !== rd || buserr !== 1'b0) begin
      failures++;
      $display("FAIL edge_ack got early=%0d c_ack=%b c_rdata=%h buserr=%b exp 0 1 %h 0", early, c_ack, c_rdata, buserr, rd);
    end
    tick();
    tick();
    checks++;
    if (buserr_cnt - b0 !== 0) begin
      failures++;
      $display("FAIL edge_buserr got=%0d exp=0", buserr_cnt - b0);
    end
    $display("test_ack_at_timeout done");
  endtask

  task automatic test_reset_in_wait();
    int          ca0, da0;
    logic [21:0] da;
    logic [15:0] rd;
    ca0 = c_ack_cnt; da0 = d_ack_cnt;
    c_gp = 0; c_wr = 0; c_addr = 22'($urandom);
    c_req = 1;
    tick();
    c_req = 0;
    repeat (3) tick();
    rst = 1;
    tick();
    rst = 0;
    checks++;
    if ({m_req, io_req, c_ack, d_ack, buserr, owner} !== 6'b0 || c_rdata !== 16'h0) begin
      failures++;
      $display("FAIL rw_reset got ctrl=%b c_rdata=%h exp 0 0", {m_req, io_req, c_ack, d_ack, buserr, owner}, c_rdata);
    end
    tick();
    m_ack = 1; m_rdata = 16'hBEEF;
    tick();
    m_ack = 0;
    repeat (3) tick();
    checks++;
    if (c_ack_cnt - ca0 !== 0 || d_ack_cnt - da0 !== 0) begin
      failures++;
      $display("FAIL rw_no_ack got c_ack=%0d d_ack=%0d exp 0 0", c_ack_cnt - ca0, d_ack_cnt - da0);
    end
    da = 22'($urandom);
    d_gp = 1; d_wr = 1; d_addr = da; d_wdata = 16'h1234;
    d_req = 1;
    tick();
    d_req = 0;
    tick();
    checks++;
    if (io_req !== 1'b1 || io_addr !== da || io_wr !== 1'b1 || owner !== 1'b1) begin
      failures++;
      $display("FAIL rw_next_issue got io_req=%b addr=%h wr=%b owner=%b exp 1 %h 1 1", io_req, io_addr, io_wr, owner, da);
    end
    repeat (2) tick();
    rd = 16'($urandom);
    io_ack = 1; io_rdata = rd;
    tick();
    io_ack = 0;
    checks++;
    if (d_ack !== 1'b1 || d_rdata !== rd || c_ack !== 1'b0) begin
      failures++;
      $display("FAIL rw_next_ack got d_ack=%b d_rdata=%h c_ack=%b exp 1 %h 0", d_ack, d_rdata, c_ack, rd);
    end
    $display("test_reset_in_wait done");
  endtask

  task automatic test_back_to_back();
    int          m0;
    logic [21:0] a1, a2;
    logic [15:0] rd;
    m0 = m_req_cnt;
    a1 = 22'($urandom); a2 = ~a1;
    c_gp = 0; c_wr = 0; c_addr = a1;
    c_req = 1;
    tick();
    c_addr = a2;
    c_req = 1;
    tick();
    c_req = 0;
    checks++;
    if (m_req !== 1'b1 || m_addr !== a1) begin
      failures++;
      $display("FAIL b2b_first got m_req=%b addr=%h exp 1 %h", m_req, m_addr, a1);
    end
    tick();
    c_req = 1;
    tick();
    c_req = 0;
    rd = 16'($urandom);
    m_ack = 1; m_rdata = rd;
    tick();
    m_ack = 0;
    checks++;
    if (c_ack !== 1'b1 || c_rdata !== rd) begin
      failures++;
      $display("FAIL b2b_ack1 got ack=%b rdata=%h exp 1 %h", c_ack, c_rdata, rd);
    end
    c_addr = a2; c_wr = 1; c_wdata = 16'h5A5A;
    c_req = 1;
    tick();
    c_req = 0;
    checks++;
    if (m_req_cnt - m0 !== 1) begin
      failures++;
      $display("FAIL b2b_single got=%0d exp=1 m_req pulses", m_req_cnt - m0);
    end
    tick();
    checks++;
    if (m_req !== 1'b1 || m_addr !== a2 || m_wr !== 1'b1 || m_wdata !== 16'h5A5A) begin
      failures++;
      $display("FAIL b2b_second got m_req=%b addr=%h wr=%b exp 1 %h 1", m_req, m_addr, m_wr, a2);
    end
    tick();
    rd = 16'($urandom);
    m_ack = 1; m_rdata = rd;
    tick();
    m_ack = 0;
    checks++;
    if (c_ack !== 1'b1 || c_rdata !== rd) begin
      failures++;
      $display("FAIL b2b_ack2 got ack=%b rdata=%h exp 1 %h", c_ack, c_rdata, rd);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_random();
    logic        last_m;
    logic [15:0] crd_m, drd_m;
    logic [1:0]  mask;
    logic        wr_m [2];
    logic        gp_m [2];
    logic [21:0] ad_m [2];
    logic [15:0] wd_m [2];
    logic        ord  [2];
    int          n, dly, who;
    logic [15:0] rd;
    bit          got;
    do_reset();
    last_m = 1'b1; crd_m = '0; drd_m = '0;
    for (int it = 0; it < 24; it++) begin
      mask = 2'($urandom_range(1, 3));
      for (int r = 0; r < 2; r++) begin
        wr_m[r] = 1'($urandom); gp_m[r] = 1'($urandom);
        ad_m[r] = 22'($urandom); wd_m[r] = 16'($urandom);
      end
      c_wr = wr_m[0]; c_gp = gp_m[0]; c_addr = ad_m[0]; c_wdata = wd_m[0];
      d_wr = wr_m[1]; d_gp = gp_m[1]; d_addr = ad_m[1]; d_wdata = wd_m[1];
      c_req = mask[0]; d_req = mask[1];
      if (mask == 2'b11) begin
        ord[0] = ~last_m; ord[1] = last_m; last_m = ord[0]; n = 2;
      end else begin
        ord[0] = mask[1]; ord[1] = 1'b0; n = 1;
      end
      tick();
      c_req = 0; d_req = 0;
      for (int s = 0; s < n; s++) begin
        who = int'(ord[s]);
        wait_treq(8, got);
        checks++;
        if (!got || owner !== ord[s] ||
            (gp_m[who] ? {io_req, m_req} : {m_req, io_req}) !== 2'b10) begin
          failures++;
          $display("FAIL rnd_grant it=%0d s=%0d got m=%b io=%b owner=%b exp owner=%b gp=%b", it, s, m_req, io_req, owner, ord[s], gp_m[who]);
        end
        checks++;
        if (gp_m[who] ? ({io_wr, io_addr, io_wdata} !== {wr_m[who], ad_m[who], wd_m[who]})
                      : ({m_wr, m_addr, m_wdata} !== {wr_m[who], ad_m[who], wd_m[who]})) begin
          failures++;
          $display("FAIL rnd_bus it=%0d s=%0d exp wr=%b addr=%h wdata=%h", it, s, wr_m[who], ad_m[who], wd_m[who]);
        end
        dly = $urandom_range(1, 5);
        for (int t = 0; t < dly; t++) begin
          tick();
          if (t == 0 && dly > 1) begin
            if (gp_m[who]) begin m_ack = 1; m_rdata = 16'hDEAD; end
            else begin io_ack = 1; io_rdata = 16'hDEAD; end
          end else begin
            m_ack = 0; io_ack = 0;
          end
        end
        rd = 16'($urandom);
        if (gp_m[who]) begin io_ack = 1; io_rdata = rd; end
        else begin m_ack = 1; m_rdata = rd; end
        tick();
        m_ack = 0; io_ack = 0;
        if (ord[s]) drd_m = rd; else crd_m = rd;
        checks++;
        if ({d_ack, c_ack} !== (ord[s] ? 2'b10 : 2'b01) || c_rdata !== crd_m || d_rdata !== drd_m || buserr !== 1'b0) begin
          failures++;
          $display("FAIL rnd_ack it=%0d s=%0d got d_ack=%b c_ack=%b crd=%h drd=%h exp owner=%b crd=%h drd=%h", it, s, d_ack, c_ack, c_rdata, d_rdata, ord[s], crd_m, drd_m);
        end
      end
      repeat ($urandom_range(1, 3)) tick();
      checks++;
      if (owner !== ord[n-1] || c_rdata !== crd_m || d_rdata !== drd_m) begin
        failures++;
        $display("FAIL rnd_hold it=%0d got owner=%b crd=%h drd=%h exp %b %h %h", it, owner, c_rdata, d_rdata, ord[n-1], crd_m, drd_m);
      end
    end
    $display("test_random done");
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_io_read();
    test_tie();
    test_timeout();
    test_ack_at_timeout();
    test_reset_in_wait();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
